// File: rtl/parity_mem_pkg.sv
// parity_mem_pkg: shared state type and parity helpers for the parity memory controller
package parity_mem_pkg;
  typedef enum logic {INIT, IDLE} state_e;
  localparam int MAX_W = 64;
  function automatic logic par(input logic [MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
  function automatic logic chk(input logic [MAX_W:0] word, input logic odd);
    return (^word) != odd;
  endfunction
endpackage

// File: rtl/parity_mem_array.sv
// parity_mem_array: plain single-port synchronous RAM with registered read, no reset
module parity_mem_array #(
  parameter int WORD_W = 9,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/parity_mem_ctrl.sv
// parity_mem_ctrl: parity-protected RAM with init sweep, checked reads and error logging
module parity_mem_ctrl
  import parity_mem_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int ODD_PARITY = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inject_err,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] err_addr,
  output logic              ready
);
  localparam int  WORD_W = DATA_W + 1;
  localparam logic ODD   = ODD_PARITY != 0;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, rd_addr_q, err_addr_q, err_addr_d, mem_addr;
  logic [DATA_W-1:0] data_out_q;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WORD_W-1:0] wdata, rdata;
  logic rd_pend_q, rd_valid_q, perr_q, sticky_q, sticky_d, ready_q;
  logic init, we, re, err;
  assign init     = state_q == INIT;
  assign we       = init | write;
  assign re       = ~init & read & ~write;
  assign mem_addr = init ? ptr_q : address;
  assign wdata    = init ? {par('0, ODD), {DATA_W{1'b0}}}
                         : {par(MAX_W'(data_in), ODD) ^ inject_err, data_in};
  assign err      = rd_pend_q & chk((MAX_W+1)'(rdata), ODD);
  parity_mem_array #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (mem_addr),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );
  always_comb begin
    state_d = (init && (&ptr_q)) ? IDLE : state_q;
    ptr_d   = init ? ptr_q + 1'b1 : ptr_q;
  end
  // a clear in the same cycle as an error is applied first, so the error re-arms the log
  always_comb begin
    err_cnt_d  = clr_err ? '0 : err_cnt_q;
    sticky_d   = clr_err ? 1'b0 : sticky_q;
    err_addr_d = clr_err ? '0 : err_addr_q;
    if (err) begin
      err_cnt_d  = (&err_cnt_d) ? err_cnt_d : err_cnt_d + CNT_W'(1);
      err_addr_d = sticky_d ? err_addr_d : rd_addr_q;
      sticky_d   = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      ready_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      err_cnt_q  <= '0;
      sticky_q   <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ready_q    <= state_d == IDLE;
      rd_pend_q  <= re;
      rd_addr_q  <= re ? address : rd_addr_q;
      data_out_q <= rd_pend_q ? rdata[DATA_W-1:0] : data_out_q;
      rd_valid_q <= rd_pend_q;
      perr_q     <= err;
      err_cnt_q  <= err_cnt_d;
      sticky_q   <= sticky_d;
      err_addr_q <= err_addr_d;
    end
  end
  assign data_out   = data_out_q;
  assign rd_valid   = rd_valid_q;
  assign parity_err = perr_q;
  assign err_count  = err_cnt_q;
  assign err_sticky = sticky_q;
  assign err_addr   = err_addr_q;
  assign ready      = ready_q;
endmodule
